// File: rtl/reg_axi_master_pkg.sv
// Shared definitions for the AXI4-Lite register master: state encoding,
// AXI response codes and the timeout counter width rule.
package reg_axi_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_REQ  = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_REQ  = 3'd3,
    ST_RD_RESP = 3'd4,
    ST_HUNG    = 3'd5
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Counter must be able to hold TIMEOUT_CYCLES itself; never narrower than 1 bit.
  function automatic int tmo_cnt_width(input int cycles);
    int w;
    w = $clog2(cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/reg_axi_master.sv
// AXI4-Lite single-outstanding master. Turns one register command into one
// AXI-Lite read or write, returns the bus response, and flags a timeout.
//
// Handshake semantics (every channel, both sides): a transfer happens on a
// rising clock edge where valid && ready are both high. A valid, once raised,
// stays high with its payload unchanged until that transfer; ready may move
// freely. rsp_valid is a one-cycle pulse with no backpressure.
//
// Timeout: the transaction may take up to TIMEOUT_CYCLES cycles after the
// accept cycle to complete its B/R handshake. If the counter reaches the limit
// without that handshake, the timeout response is pulsed the next cycle (the
// same one-cycle lag as a normal response) and the master parks in HUNG until
// reset. A handshake in the limit cycle is a normal completion.
module reg_axi_master
  import reg_axi_master_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                        m_axi_aclk,
  input  logic                        m_axi_aresetn,
  // command / response interface
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_wr,
  input  logic [AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [AXI_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                        rsp_valid,
  output logic [AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                  rsp_resp,
  output logic                        rsp_timeout,
  output logic                        busy,
  // AW channel
  output logic [AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [2:0]                  m_axi_awprot,
  output logic                        m_axi_awvalid,
  input  logic                        m_axi_awready,
  // W channel
  output logic [AXI_DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                        m_axi_wvalid,
  input  logic                        m_axi_wready,
  // B channel
  input  logic [1:0]                  m_axi_bresp,
  input  logic                        m_axi_bvalid,
  output logic                        m_axi_bready,
  // AR channel
  output logic [AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [2:0]                  m_axi_arprot,
  output logic                        m_axi_arvalid,
  input  logic                        m_axi_arready,
  // R channel
  input  logic [AXI_DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]                  m_axi_rresp,
  input  logic                        m_axi_rvalid,
  output logic                        m_axi_rready,
  // debug: current FSM state
  output logic [2:0]                  dbg_state
);

  localparam int SW  = AXI_DATA_WIDTH / 8;
  localparam int CW  = tmo_cnt_width(TIMEOUT_CYCLES);
  localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CW-1:0] TMO_MAX = CW'(TIMEOUT_CYCLES);

  state_e                    state_q, state_d;
  logic                      awvalid_q, awvalid_d;
  logic                      wvalid_q, wvalid_d;
  logic                      aw_done_q, aw_done_d;
  logic                      w_done_q, w_done_d;
  logic                      bready_q, bready_d;
  logic                      arvalid_q, arvalid_d;
  logic                      rready_q, rready_d;
  logic [AXI_ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [AXI_ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [SW-1:0]             wstrb_q, wstrb_d;
  logic                      rsp_valid_q, rsp_valid_d;
  logic [AXI_DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]                rsp_resp_q, rsp_resp_d;
  logic                      rsp_timeout_q, rsp_timeout_d;
  logic [CW-1:0]             cnt_q, cnt_d;

  logic accept, aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic in_txn, tmo_hit;
  logic [CW-1:0] cnt_inc;

  assign aw_hs   = awvalid_q && m_axi_awready;
  assign w_hs    = wvalid_q && m_axi_wready;
  assign b_hs    = bready_q && m_axi_bvalid;
  assign ar_hs   = arvalid_q && m_axi_arready;
  assign r_hs    = rready_q && m_axi_rvalid;
  assign accept  = cmd_valid && (state_q == ST_IDLE);
  assign in_txn  = state_q inside {ST_WR_REQ, ST_WR_RESP, ST_RD_REQ, ST_RD_RESP};
  assign cnt_inc = cnt_q + CW'(1);
  // The completing handshake beats the limit when both land in one cycle.
  assign tmo_hit = TMO_EN && in_txn && (cnt_inc == TMO_MAX) && !(b_hs || r_hs);

  // Next-state and next-register-value logic.
  always_comb begin
    state_d       = state_q;
    awvalid_d     = awvalid_q;
    wvalid_d      = wvalid_q;
    aw_done_d     = aw_done_q;
    w_done_d      = w_done_q;
    bready_d      = bready_q;
    arvalid_d     = arvalid_q;
    rready_d      = rready_q;
    awaddr_d      = awaddr_q;
    araddr_d      = araddr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_resp_d    = rsp_resp_q;
    rsp_timeout_d = rsp_timeout_q;
    cnt_d         = cnt_q;

    // Handshakes retire their valid/ready in every state, HUNG included,
    // so a late slave never sees a duplicated transfer.
    if (aw_hs) begin
      awvalid_d = 1'b0;
      aw_done_d = 1'b1;
    end
    if (w_hs) begin
      wvalid_d = 1'b0;
      w_done_d = 1'b1;
    end
    if (ar_hs) arvalid_d = 1'b0;
    if (b_hs)  bready_d  = 1'b0;
    if (r_hs)  rready_d  = 1'b0;

    // Timeout counter: cleared on accept, saturating count while busy.
    if (accept) begin
      cnt_d = '0;
    end else if (TMO_EN && (state_q != ST_IDLE) && (cnt_q != TMO_MAX)) begin
      cnt_d = cnt_inc;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          awaddr_d  = cmd_addr;
          araddr_d  = cmd_addr;
          wdata_d   = cmd_wdata;
          wstrb_d   = cmd_wstrb;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          if (cmd_wr) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = ST_WR_REQ;
          end else begin
            arvalid_d = 1'b1;
            state_d   = ST_RD_REQ;
          end
        end
      end
      ST_WR_REQ: begin
        if (tmo_hit) begin
          state_d = ST_HUNG;
        end else if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
          bready_d = 1'b1;
          state_d  = ST_WR_RESP;
        end
      end
      ST_WR_RESP: begin
        if (b_hs) begin
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = '0;
          rsp_resp_d    = m_axi_bresp;
          rsp_timeout_d = 1'b0;
          state_d       = ST_IDLE;
        end else if (tmo_hit) begin
          state_d = ST_HUNG;
        end
      end
      ST_RD_REQ: begin
        if (tmo_hit) begin
          state_d = ST_HUNG;
        end else if (ar_hs) begin
          rready_d = 1'b1;
          state_d  = ST_RD_RESP;
        end
      end
      ST_RD_RESP: begin
        if (r_hs) begin
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = m_axi_rdata;
          rsp_resp_d    = m_axi_rresp;
          rsp_timeout_d = 1'b0;
          state_d       = ST_IDLE;
        end else if (tmo_hit) begin
          state_d = ST_HUNG;
        end
      end
      ST_HUNG: state_d = ST_HUNG;
      default: state_d = ST_IDLE;
    endcase

    if (tmo_hit) begin
      rsp_valid_d   = 1'b1;
      rsp_rdata_d   = '0;
      rsp_resp_d    = RESP_SLVERR;
      rsp_timeout_d = 1'b1;
    end
  end

  // State and output registers; reset clears everything and returns to IDLE.
  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      state_q       <= ST_IDLE;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      aw_done_q     <= 1'b0;
      w_done_q      <= 1'b0;
      bready_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      awaddr_q      <= '0;
      araddr_q      <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_resp_q    <= 2'b00;
      rsp_timeout_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      awvalid_q     <= awvalid_d;
      wvalid_q      <= wvalid_d;
      aw_done_q     <= aw_done_d;
      w_done_q      <= w_done_d;
      bready_q      <= bready_d;
      arvalid_q     <= arvalid_d;
      rready_q      <= rready_d;
      awaddr_q      <= awaddr_d;
      araddr_q      <= araddr_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_resp_q    <= rsp_resp_d;
      rsp_timeout_q <= rsp_timeout_d;
      cnt_q         <= cnt_d;
    end
  end

  assign cmd_ready     = (state_q == ST_IDLE);
  assign busy          = (state_q != ST_IDLE);
  assign dbg_state     = state_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_resp      = rsp_resp_q;
  assign rsp_timeout   = rsp_timeout_q;
  assign m_axi_awaddr  = awaddr_q;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = bready_q;
  assign m_axi_araddr  = araddr_q;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;

endmodule
